noc_mux: RTL and testbench

- Two-input, one-output flit multiplexer for the router datapath.
- Steers one of two input ports (data, valid, virtual channel) onto a single output port, as selected by a one-hot select vector.
- Output stage is registered, giving a clean timing and energy characterization boundary between the crossbar and the output link.
- Unselected input data never toggles the output register.

---
 rtl/noc_pkg.sv | 18 +
 rtl/noc_mux_stats.sv | 39 +++
 rtl/noc_mux.sv | 80 ++++++++
 tb/tb_noc_mux.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared router datapath definitions: flit type codes, default widths and the flit layout.
package noc_pkg;

   localparam int DEF_DATA_W = 66;
   localparam int DEF_VCH_W  = 2;
   localparam int DEF_SEL_W  = 5;

   localparam logic [1:0] TYPE_NONE = 2'b00;
   localparam logic [1:0] TYPE_HEAD = 2'b01;
   localparam logic [1:0] TYPE_DATA = 2'b10;
   localparam logic [1:0] TYPE_TAIL = 2'b11;

   typedef struct packed {
      logic [1:0]  ftype;
      logic [63:0] payload;
   } flit_t;

endpackage

// File: rtl/noc_mux_stats.sv
// Flit and odata bit-toggle counters; tracks the output register 1:1, no backpressure.
module noc_mux_stats #(
   parameter int DATA_W = 66
) (
   input  logic              clk,
   input  logic              rst_,
   input  logic              vld_nxt,
   input  logic [DATA_W-1:0] data_nxt,
   input  logic [DATA_W-1:0] data_cur,
   output logic [31:0]       flit_cnt,
   output logic [31:0]       toggle_cnt
);

   localparam int CW = $clog2(DATA_W + 1);

   logic [CW-1:0] flips;
   logic [32:0]   tsum;

   always_comb begin
      flips = '0;
      for (int i = 0; i < DATA_W; i++) begin
         flips = flips + CW'(data_nxt[i] ^ data_cur[i]);
      end
   end

   assign tsum = {1'b0, toggle_cnt} + 33'(flips);

   // flit_cnt wraps freely; toggle_cnt pins at all-ones so long runs never alias to small values
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         flit_cnt   <= '0;
         toggle_cnt <= '0;
      end else begin
         flit_cnt   <= flit_cnt + 32'(vld_nxt);
         toggle_cnt <= tsum[32] ? 32'hFFFF_FFFF : tsum[31:0];
      end
   end

endmodule

// File: rtl/noc_mux.sv
// 2:1 one-hot flit steering register (port 0 wins conflicts), 1-cycle latency, no backpressure.
// Defining NOC_MUX_STATS_EN adds the flit_cnt/toggle_cnt outputs via noc_mux_stats.
module noc_mux
   import noc_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int VCH_W  = DEF_VCH_W,
   parameter int SEL_W  = DEF_SEL_W
) (
   input  logic              clk,
   input  logic              rst_,
   input  logic [DATA_W-1:0] idata_0,
   input  logic              ivalid_0,
   input  logic [VCH_W-1:0]  ivch_0,
   input  logic [DATA_W-1:0] idata_1,
   input  logic              ivalid_1,
   input  logic [VCH_W-1:0]  ivch_1,
   input  logic [SEL_W-1:0]  sel,
   output logic [DATA_W-1:0] odata,
   output logic              ovalid,
   output logic [VCH_W-1:0]  ovch,
`ifdef NOC_MUX_STATS_EN
   output logic [31:0]       flit_cnt,
   output logic [31:0]       toggle_cnt,
`endif
   output logic              sel_err
);

   logic [DATA_W-1:0] data_nxt;
   logic [VCH_W-1:0]  vch_nxt;
   logic              vld_nxt;
   logic              unused_sel;

   assign unused_sel = ^sel[SEL_W-1:2];

   // With no port selected the data/vch registers recirculate so idle inputs never toggle them
   always_comb begin
      data_nxt = odata;
      vch_nxt  = ovch;
      vld_nxt  = 1'b0;
      if (sel[0]) begin
         data_nxt = idata_0;
         vch_nxt  = ivch_0;
         vld_nxt  = ivalid_0;
      end else if (sel[1]) begin
         data_nxt = idata_1;
         vch_nxt  = ivch_1;
         vld_nxt  = ivalid_1;
      end
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         odata   <= '0;
         ovalid  <= 1'b0;
         ovch    <= '0;
         sel_err <= 1'b0;
      end else begin
         odata   <= data_nxt;
         ovalid  <= vld_nxt;
         ovch    <= vch_nxt;
         sel_err <= sel[0] & sel[1];
      end
   end

`ifdef NOC_MUX_STATS_EN
   noc_mux_stats #(
      .DATA_W (DATA_W)
   ) u_stats (
      .clk        (clk),
      .rst_       (rst_),
      .vld_nxt    (vld_nxt),
      .data_nxt   (data_nxt),
      .data_cur   (odata),
      .flit_cnt   (flit_cnt),
      .toggle_cnt (toggle_cnt)
   );
`endif

endmodule

// File: tb/tb_noc_mux.sv
// Randomized scoreboard bench for noc_mux; checks counters too when NOC_MUX_STATS_EN is defined.
module tb_noc_mux;
   import noc_pkg::*;

   localparam int DW = DEF_DATA_W;
   localparam int VW = DEF_VCH_W;
   localparam int SW = DEF_SEL_W;

   logic          clk = 1'b0;
   logic          rst_ = 1'b0;
   logic [DW-1:0] idata_0 = '0, idata_1 = '0;
   logic          ivalid_0 = 1'b0, ivalid_1 = 1'b0;
   logic [VW-1:0] ivch_0 = '0, ivch_1 = '0;
   logic [SW-1:0] sel = '0;
   logic [DW-1:0] odata;
   logic          ovalid;
   logic [VW-1:0] ovch;
   logic          sel_err;
`ifdef NOC_MUX_STATS_EN
   logic [31:0]   flit_cnt, toggle_cnt;
`endif

   noc_mux dut (
      .clk        (clk),
      .rst_       (rst_),
      .idata_0    (idata_0),
      .ivalid_0   (ivalid_0),
      .ivch_0     (ivch_0),
      .idata_1    (idata_1),
      .ivalid_1   (ivalid_1),
      .ivch_1     (ivch_1),
      .sel        (sel),
      .odata      (odata),
      .ovalid     (ovalid),
      .ovch       (ovch),
`ifdef NOC_MUX_STATS_EN
      .flit_cnt   (flit_cnt),
      .toggle_cnt (toggle_cnt),
`endif
      .sel_err    (sel_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int            due;
      logic [DW-1:0] d;
      logic          v;
      logic [VW-1:0] c;
      logic          e;
      logic [31:0]   fc;
      longint        tc;
   } exp_t;

   exp_t sb[$];
   int   cyc  = 0;
   int   nvec = 0;
   int   nerr = 0;

   // reference state: what the output link should show after the last scheduled edge
   logic [DW-1:0] m_d  = '0;
   logic          m_v  = 1'b0;
   logic [VW-1:0] m_c  = '0;
   logic          m_e  = 1'b0;
   logic [31:0]   m_fc = '0;
   longint        m_tc = 0;

   always @(posedge clk) cyc++;

   task automatic check(input string nm, input logic [65:0] act, input logic [65:0] req);
      nvec++;
      if (act !== req) begin
         nerr++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, req);
      end
   endtask

   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         exp_t e;
         e = sb.pop_front();
         check("odata", odata, e.d);
         check("ovalid", 66'(ovalid), 66'(e.v));
         check("ovch", 66'(ovch), 66'(e.c));
         check("sel_err", 66'(sel_err), 66'(e.e));
`ifdef NOC_MUX_STATS_EN
         check("flit_cnt", 66'(flit_cnt), 66'(e.fc));
         check("toggle_cnt", 66'(toggle_cnt), 66'(e.tc));
`endif
      end
   end

   function automatic flit_t rnd_flit();
      flit_t f;
      f.ftype   = 2'($urandom_range(0, 3));
      f.payload = {$urandom, $urandom};
      return f;
   endfunction

   function automatic flit_t mk_flit(input logic [1:0] t, input logic [63:0] p);
      flit_t f;
      f.ftype   = t;
      f.payload = p;
      return f;
   endfunction

   task automatic step(input logic r, input logic [SW-1:0] s,
                       input flit_t f0, input logic v0, input logic [VW-1:0] c0,
                       input flit_t f1, input logic v1, input logic [VW-1:0] c1);
      exp_t          e;
      logic          was_high;
      logic [DW-1:0] nd;
      logic          nv;
      @(posedge clk);
      #1;
      was_high = rst_;
      rst_     = r;
      sel      = s;
      idata_0  = f0;
      ivalid_0 = v0;
      ivch_0   = c0;
      idata_1  = f1;
      ivalid_1 = v1;
      ivch_1   = c1;
      if (!r) begin
         // asynchronous clear: anything not yet observed is gone too
         foreach (sb[i]) begin
            sb[i].d  = '0;
            sb[i].v  = 1'b0;
            sb[i].c  = '0;
            sb[i].e  = 1'b0;
            sb[i].fc = '0;
            sb[i].tc = 0;
         end
         m_d = '0; m_v = 1'b0; m_c = '0; m_e = 1'b0; m_fc = '0; m_tc = 0;
      end else begin
         nd = m_d;
         nv = 1'b0;
         case (s[1:0])
            2'b01, 2'b11: begin nd = f0; nv = v0; m_c = c0; end
            2'b10:        begin nd = f1; nv = v1; m_c = c1; end
            default:      ;
         endcase
         m_e = (s[1:0] == 2'b11);
         if (nv) m_fc = m_fc + 32'd1;
         m_tc = m_tc + longint'($countones(nd ^ m_d));
         if (m_tc > 64'hFFFF_FFFF) m_tc = 64'hFFFF_FFFF;
         m_d = nd;
         m_v = nv;
      end
      e.due = cyc + 1;
      e.d = m_d; e.v = m_v; e.c = m_c; e.e = m_e; e.fc = m_fc; e.tc = m_tc;
      sb.push_back(e);
      if (!r && was_high) begin
         #1;
         check("async_rst_odata", odata, '0);
         check("async_rst_ovalid", 66'(ovalid), 66'(0));
      end
   endtask

   task automatic rnd_step(input logic r, input logic [SW-1:0] s);
      step(r, s, rnd_flit(), 1'($urandom), VW'($urandom), rnd_flit(), 1'($urandom), VW'($urandom));
   endtask

   initial begin
      flit_t         f;
      logic [VW-1:0] vc;
      logic [SW-1:0] ps;

      for (int i = 0; i < 6; i++) rnd_step(1'b0, 5'b00010);

      // port-1 packet while port 0 carries unrelated traffic
      vc = VW'($urandom);
      step(1'b1, 5'b00010, rnd_flit(), 1'b1, VW'($urandom), mk_flit(TYPE_HEAD, 64'h4), 1'b1, vc);
      for (int i = 0; i < 20; i++) begin
         f = mk_flit(TYPE_DATA, (i % 2 == 0) ? 64'hAAAA_AAAA_AAAA_AAAA : 64'h5555_5555_5555_5555);
         step(1'b1, 5'b00010, rnd_flit(), 1'b1, VW'($urandom), f, 1'b1, vc);
      end
      step(1'b1, 5'b00010, rnd_flit(), 1'b1, VW'($urandom), mk_flit(TYPE_TAIL, 64'hDEAD_BEEF), 1'b1, vc);

      step(1'b1, 5'b00001, mk_flit(TYPE_HEAD, 64'h9), 1'b1, 2'd3, rnd_flit(), 1'b1, 2'd1);

      for (int i = 0; i < 5; i++) rnd_step(1'b1, 5'b00000);

      step(1'b1, 5'b00011, rnd_flit(), 1'b1, 2'd2, rnd_flit(), 1'b1, 2'd1);
      step(1'b1, 5'b00010, rnd_flit(), 1'b1, 2'd0, rnd_flit(), 1'b1, 2'd3);
      step(1'b1, 5'b11101, rnd_flit(), 1'b0, 2'd1, rnd_flit(), 1'b1, 2'd2);

      // mid-packet reset
      step(1'b1, 5'b00001, rnd_flit(), 1'b1, 2'd1, rnd_flit(), 1'b1, 2'd2);
      rnd_step(1'b0, 5'b00001);
      rnd_step(1'b1, 5'b00001);

      for (int i = 0; i < 300; i++) rnd_step(($urandom_range(0, 49) != 0), SW'($urandom));

      // 10 packets of 22 flits separated by 7 idle cycles, counters start from reset
      rnd_step(1'b0, 5'b00000);
      rnd_step(1'b0, 5'b00000);
      for (int p = 0; p < 10; p++) begin
         ps = (p % 2 == 0) ? 5'b00001 : 5'b00010;
         for (int k = 0; k < 22; k++) begin
            f = mk_flit((k == 0) ? TYPE_HEAD : (k == 21) ? TYPE_TAIL : TYPE_DATA, {$urandom, $urandom});
            step(1'b1, ps, f, 1'b1, VW'(p), f, 1'b1, VW'(p));
         end
         for (int k = 0; k < 7; k++) rnd_step(1'b1, 5'b00000);
      end

      repeat (3) @(posedge clk);
      @(negedge clk);
`ifdef NOC_MUX_STATS_EN
      check("flit_cnt_total", 66'(flit_cnt), 66'd220);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, time %0t, expected completion", $time);
      $fatal(1, "watchdog");
   end

endmodule
